// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle add/sub/logic, iterative 1-bit-per-cycle
// shifts and unsigned shift-add multiply, one operation in flight at a time.
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       status,
  output logic             illegal
);

  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SL  = 4'b0101;
  localparam logic [3:0] OP_SR  = 4'b0011;
  localparam logic [3:0] OP_SRA = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic odd_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  function automatic logic [4:0] make_status(input logic [WIDTH-1:0] res,
                                             input logic ovf, input logic cy);
    return {ovf, res[WIDTH-1], (res == {WIDTH{1'b0}}), odd_parity(res), cy};
  endfunction

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [4:0]         status_q, status_d;
  logic               illegal_q, illegal_d;

  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   diff_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_cy_s, alu_ovf_s, alu_ill_s;
  logic               is_mul_s, is_shift_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] prod_step_s;
  logic [WIDTH-1:0]   sh_step_s;
  logic               sh_out_s;

  assign shamt_s = b[SHAMT_W-1:0];

  // Single-cycle evaluation straight from the offered operands
  always_comb begin
    sum_s      = {1'b0, a} + {1'b0, b};
    diff_s     = a - b;
    alu_res_s  = {WIDTH{1'b0}};
    alu_cy_s   = 1'b0;
    alu_ovf_s  = 1'b0;
    alu_ill_s  = 1'b0;
    is_mul_s   = 1'b0;
    is_shift_s = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_cy_s  = sum_s[WIDTH];
        alu_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_cy_s  = (a >= b);
        alu_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res_s = a & b;
      OP_OR:  alu_res_s = a | b;
      OP_XOR: alu_res_s = a ^ b;
      OP_SL, OP_SR, OP_SRA: begin
        alu_res_s  = a;
        is_shift_s = 1'b1;
      end
      OP_MUL:  is_mul_s  = 1'b1;
      default: alu_ill_s = 1'b1;
    endcase
  end

  // One iteration step: multiply accumulates into the upper half while the
  // multiplier drains out of the lower half; shifts move opnd_q by one bit
  always_comb begin
    mul_sum_s   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + {1'b0, (prod_q[0] ? opnd_q : {WIDTH{1'b0}})};
    prod_step_s = {mul_sum_s, prod_q[WIDTH-1:1]};
    case (op_q)
      OP_SL: begin
        sh_step_s = {opnd_q[WIDTH-2:0], 1'b0};
        sh_out_s  = opnd_q[WIDTH-1];
      end
      OP_SRA: begin
        sh_step_s = {opnd_q[WIDTH-1], opnd_q[WIDTH-1:1]};
        sh_out_s  = opnd_q[0];
      end
      OP_SR: begin
        sh_step_s = {1'b0, opnd_q[WIDTH-1:1]};
        sh_out_s  = opnd_q[0];
      end
      default: begin
        sh_step_s = {1'b0, opnd_q[WIDTH-1:1]};
        sh_out_s  = opnd_q[0];
      end
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    status_d  = status_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d   = op;
          opnd_d = a;
          prod_d = {{WIDTH{1'b0}}, b};
          if (is_mul_s) begin
            cnt_d   = CNT_W'(WIDTH);
            state_d = ST_BUSY;
          end else if (is_shift_s && (shamt_s != {SHAMT_W{1'b0}})) begin
            cnt_d   = {1'b0, shamt_s};
            state_d = ST_BUSY;
          end else begin
            result_d  = alu_res_s;
            status_d  = make_status(alu_res_s, alu_ovf_s, alu_cy_s);
            illegal_d = alu_ill_s;
            state_d   = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q == OP_MUL) begin
          prod_d = prod_step_s;
        end else begin
          opnd_d = sh_step_s;
        end
        // Status is taken from the stepped value so it always matches this result
        if (cnt_q == CNT_W'(1)) begin
          state_d   = ST_DONE;
          illegal_d = 1'b0;
          if (op_q == OP_MUL) begin
            result_d = prod_step_s[WIDTH-1:0];
            status_d = make_status(prod_step_s[WIDTH-1:0],
                                   |prod_step_s[2*WIDTH-1:WIDTH], 1'b0);
          end else begin
            result_d = sh_step_s;
            status_d = make_status(sh_step_s, 1'b0, sh_out_s);
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 4'b0000;
      opnd_q    <= {WIDTH{1'b0}};
      prod_q    <= {(2*WIDTH){1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      result_q  <= {WIDTH{1'b0}};
      status_q  <= 5'b00000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      status_q  <= status_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign status    = status_q;
  assign illegal   = illegal_q;

endmodule
